// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-PC generator: state encoding,
// default boot vector and fetch-group arithmetic.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Width of a slot index; a single-slot group still needs a 1-bit port.
    function automatic int slot_bits(input int fetch_width);
        return (fetch_width > 1) ? $clog2(fetch_width) : 1;
    endfunction

    // Aligned start of the following group. Shifting back left drops the
    // carry out of bit 31, so the group number wraps modulo 2^(32-gb).
    function automatic logic [31:0] group_next(input logic [31:0] pc,
                                               input int          gb);
        logic [31:0] grp;
        grp = pc >> gb;
        grp = grp + 32'd1;
        return grp << gb;
    endfunction

endpackage

// File: rtl/pc_slot_mask.sv
// Offset-to-mask decoder: slot i is valid when i is at or after the slot
// index of the first fetched instruction. enable=0 forces an empty mask.
module pc_slot_mask
    import pc_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int SBW         = slot_bits(FETCH_WIDTH)
) (
    input  logic [SBW-1:0]         slot_idx,
    input  logic                   enable,
    output logic [FETCH_WIDTH-1:0] mask
);

    logic [31:0] idx_ext;

    always_comb begin
        idx_ext = 32'(slot_idx);
        mask    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask[i] = enable && (32'(i) >= idx_ext);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-group PC generator with exc > br (> pred) > sequential redirect priority.
// Optional branch-prediction input port pair enabled by `define PC_PREDICT_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int          FETCH_WIDTH = 4,
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [31:0]            fetch_pc,
    output logic [31:0]            fetch_npc,
    output logic [31:0]            fetch_nnpc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   fetch_adel,
    input  logic                   exc_redirect_valid,
    input  logic [31:0]            exc_redirect_pc,
    input  logic                   br_redirect_valid,
    input  logic [31:0]            br_redirect_pc,
`ifdef PC_PREDICT_EN
    input  logic                   pred_valid,
    input  logic [31:0]            pred_pc,
`endif
    input  logic                   halt_req
);

    localparam int GB  = $clog2(FETCH_WIDTH * 4);
    localparam int SB  = $clog2(FETCH_WIDTH);
    localparam int SBW = slot_bits(FETCH_WIDTH);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;

    logic [31:0]    group_nnpc;
    logic [31:0]    seq_target;
    logic           handshake;
    logic [SBW-1:0] slot_idx;

    assign group_nnpc = group_next(pc_q, GB);
    assign handshake  = fetch_valid_q && fetch_ready && (state_q == RUN);

`ifdef PC_PREDICT_EN
    assign seq_target = pred_valid ? pred_pc : group_nnpc;
`else
    assign seq_target = group_nnpc;
`endif

    // Next-state / next-pc selection; a redirect overrides every state
    // and ignores fetch_ready because it flushes the offered group.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (exc_redirect_valid) begin
            pc_d    = exc_redirect_pc;
            state_d = (exc_redirect_pc[1:0] != 2'b00) ? ERR : RUN;
        end else if (br_redirect_valid) begin
            pc_d    = br_redirect_pc;
            state_d = (br_redirect_pc[1:0] != 2'b00) ? ERR : RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (handshake) begin
                        pc_d    = seq_target;
                        state_d = (seq_target[1:0] != 2'b00) ? ERR : RUN;
                    end
                    // Halt lands after the advance so the accepted group is not lost.
                    if (halt_req) begin
                        state_d = HALT;
                    end
                end
                HALT:    state_d = HALT;
                ERR:     state_d = ERR;
                default: state_d = BOOT;
            endcase
        end
        fetch_valid_d = (state_d == RUN) || (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    generate
        if (SB > 0) begin : g_slot
            assign slot_idx = pc_q[GB-1:2];
        end else begin : g_single
            assign slot_idx = '0;
        end
    endgenerate

    pc_slot_mask #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .SBW         (SBW)
    ) u_slot_mask (
        .slot_idx (slot_idx),
        .enable   (state_q != ERR),
        .mask     (fetch_mask)
    );

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = pc_q;
    assign fetch_npc   = pc_q + 32'd4;
    assign fetch_nnpc  = group_nnpc;
    assign fetch_adel  = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (FETCH_WIDTH=4, RESET_PC=BFC0_0000):
// expected groups are queued when stimulus is driven and checked after the edge.
module tb_pc_gen;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  mask;
        logic        adel;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_npc;
    logic [31:0] fetch_nnpc;
    logic [3:0]  fetch_mask;
    logic        fetch_adel;
    logic        exc_redirect_valid;
    logic [31:0] exc_redirect_pc;
    logic        br_redirect_valid;
    logic [31:0] br_redirect_pc;
    logic        halt_req;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    pc_gen #(
        .FETCH_WIDTH (4),
        .RESET_PC    (32'hBFC0_0000)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_ready        (fetch_ready),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .fetch_npc          (fetch_npc),
        .fetch_nnpc         (fetch_nnpc),
        .fetch_mask         (fetch_mask),
        .fetch_adel         (fetch_adel),
        .exc_redirect_valid (exc_redirect_valid),
        .exc_redirect_pc    (exc_redirect_pc),
        .br_redirect_valid  (br_redirect_valid),
        .br_redirect_pc     (br_redirect_pc),
        .halt_req           (halt_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] pc,
                                input logic [3:0] m, input logic a);
        exp_t e;
        e.valid = v;
        e.pc    = pc;
        e.mask  = m;
        e.adel  = a;
        return e;
    endfunction

    task automatic check_now(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(fetch_valid), 32'(e.valid));
        check({tag, ".pc"},    fetch_pc, e.pc);
        check({tag, ".npc"},   fetch_npc, e.pc + 32'd4);
        check({tag, ".nnpc"},  fetch_nnpc, (e.pc | 32'h0000_000F) + 32'd1);
        check({tag, ".mask"},  32'(fetch_mask), 32'(e.mask));
        check({tag, ".adel"},  32'(fetch_adel), 32'(e.adel));
    endtask

    // Queue what the next edge must produce, advance one clock, compare.
    task automatic step(input string tag, input exp_t e);
        exp_t got;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_now(tag, got);
        end
    endtask

    task automatic clear_redirects();
        exc_redirect_valid = 1'b0;
        br_redirect_valid  = 1'b0;
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst_n              = 1'b0;
        fetch_ready        = 1'b1;
        exc_redirect_valid = 1'b0;
        exc_redirect_pc    = 32'h0;
        br_redirect_valid  = 1'b0;
        br_redirect_pc     = 32'h0;
        halt_req           = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_now("reset", mk(1'b0, 32'hBFC0_0000, 4'b1111, 1'b0));
        rst_n = 1'b1;
        #2;
        check_now("boot", mk(1'b0, 32'hBFC0_0000, 4'b1111, 1'b0));
        @(posedge clk);
        #1;
        check_now("run0", mk(1'b1, 32'hBFC0_0000, 4'b1111, 1'b0));
        step("seq1", mk(1'b1, 32'hBFC0_0010, 4'b1111, 1'b0));
        step("seq2", mk(1'b1, 32'hBFC0_0020, 4'b1111, 1'b0));

        fetch_ready       = 1'b0;
        br_redirect_valid = 1'b1;
        br_redirect_pc    = 32'h8000_0008;
        step("br", mk(1'b1, 32'h8000_0008, 4'b1100, 1'b0));
        clear_redirects();
        fetch_ready = 1'b1;
        step("br_hs", mk(1'b1, 32'h8000_0010, 4'b1111, 1'b0));

        exc_redirect_valid = 1'b1;
        exc_redirect_pc    = 32'hBFC0_0380;
        br_redirect_valid  = 1'b1;
        br_redirect_pc     = 32'h8000_1000;
        step("exc_wins", mk(1'b1, 32'hBFC0_0380, 4'b1111, 1'b0));
        clear_redirects();

        fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("stall%0d", i), mk(1'b1, 32'hBFC0_0380, 4'b1111, 1'b0));
        end
        fetch_ready = 1'b1;
        step("unstall", mk(1'b1, 32'hBFC0_0390, 4'b1111, 1'b0));

        halt_req = 1'b1;
        step("halt", mk(1'b0, 32'hBFC0_03A0, 4'b1111, 1'b0));
        halt_req = 1'b0;
        step("halt_hold", mk(1'b0, 32'hBFC0_03A0, 4'b1111, 1'b0));
        step("halt_hold2", mk(1'b0, 32'hBFC0_03A0, 4'b1111, 1'b0));
        exc_redirect_valid = 1'b1;
        exc_redirect_pc    = 32'hBFC0_0380;
        fetch_ready        = 1'b0;
        step("halt_exit", mk(1'b1, 32'hBFC0_0380, 4'b1111, 1'b0));
        clear_redirects();

        br_redirect_valid = 1'b1;
        br_redirect_pc    = 32'h8000_0002;
        step("err", mk(1'b1, 32'h8000_0002, 4'b0000, 1'b1));
        clear_redirects();
        fetch_ready = 1'b1;
        step("err_hold", mk(1'b1, 32'h8000_0002, 4'b0000, 1'b1));
        step("err_hold2", mk(1'b1, 32'h8000_0002, 4'b0000, 1'b1));
        exc_redirect_valid = 1'b1;
        exc_redirect_pc    = 32'hBFC0_0380;
        step("err_exit", mk(1'b1, 32'hBFC0_0380, 4'b1111, 1'b0));
        clear_redirects();

        br_redirect_valid = 1'b1;
        br_redirect_pc    = 32'h8000_000C;
        step("slot3", mk(1'b1, 32'h8000_000C, 4'b1000, 1'b0));
        br_redirect_pc = 32'hFFFF_FFF0;
        fetch_ready    = 1'b0;
        step("top", mk(1'b1, 32'hFFFF_FFF0, 4'b1111, 1'b0));
        clear_redirects();
        fetch_ready = 1'b1;
        step("wrap", mk(1'b1, 32'h0000_0000, 4'b1111, 1'b0));

        #2;
        rst_n = 1'b0;
        #2;
        check_now("async_rst", mk(1'b0, 32'hBFC0_0000, 4'b1111, 1'b0));
        br_redirect_valid = 1'b1;
        br_redirect_pc    = 32'h8000_0040;
        rst_n             = 1'b1;
        step("boot_redir", mk(1'b1, 32'h8000_0040, 4'b1111, 1'b0));
        clear_redirects();
        step("boot_redir_seq", mk(1'b1, 32'h8000_0050, 4'b1111, 1'b0));

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-PC generator; successor to the single-issue PC register. Produces a fetch-group PC with a valid/ready handshake toward the instruction fetch stage. Applies exception and branch redirects with fixed priority. Advances by aligned fetch groups and emits a per-slot valid mask. Sits at the head of the front end, between the redirect sources (commit/branch unit) and the icache request port.

Parameters:
FETCH_WIDTH, 4, instructions per fetch group; power of 2, range 1..8.
RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
Derived (localparam): GB = log2(FETCH_WIDTH*4), the byte-offset bits of a group; SB = log2(FETCH_WIDTH), the slot-index bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_ready  in  1  fetch stage accepts the current group
fetch_valid  out  1  current group is valid
fetch_pc  out  32  PC of the first valid slot
fetch_npc  out  32  fetch_pc + 4
fetch_nnpc  out  32  aligned start of the next group: {fetch_pc[31:GB]+1, GB'b0}
fetch_mask  out  FETCH_WIDTH  slot i valid iff i >= fetch_pc[GB-1:2]
fetch_adel  out  1  fetch_pc[1:0] != 0 (address-error flag travels with the group)
exc_redirect_valid  in  1  exception/eret redirect
exc_redirect_pc  in  32  exception target
br_redirect_valid  in  1  branch mispredict redirect
br_redirect_pc  in  32  branch target
halt_req  in  1  stop issuing (wait/idle)

Behaviour:
- Reset (rst_n low, asynchronous): pc = RESET_PC, state = BOOT, fetch_valid = 0. fetch_pc, fetch_npc, fetch_nnpc and fetch_mask are derived combinationally from pc.
- States:
  - BOOT: fetch_valid = 0 for exactly one cycle after reset releases, then RUN.
  - RUN: fetch_valid = 1.
  - HALT: fetch_valid = 0.
  - ERR: fetch_valid = 1, fetch_adel = 1, pc frozen.
- Next-pc priority, evaluated every cycle in every state: exc_redirect > br_redirect > sequential.
  - Any redirect loads pc = target on the next edge, regardless of fetch_ready.
  - The redirect is a flush. The fetch stage discards the unaccepted group. The valid-stable rule does not apply across a redirect.
  - After a redirect, state = RUN, or ERR if target[1:0] != 0.
  - A redirect in BOOT is accepted and BOOT still ends.
- Sequential advance: only in RUN, only on fetch_valid && fetch_ready. pc = fetch_nnpc.
  - fetch_valid && !fetch_ready: pc and all outputs hold.
  - Wrap-around: pc[31:GB] increments modulo 2^(32-GB). 32'hFFFF_FFF0 with FETCH_WIDTH=4 wraps to 0.
- halt_req in RUN with no redirect: state = HALT on the next edge. halt_req is applied after any concurrent handshake advance.
  - HALT exits only on a redirect. Deasserting halt_req alone does not exit HALT.
- ERR: the group is offered repeatedly until a redirect arrives. fetch_mask is all zeros in ERR.
- Latency: redirect to fetch_pc = target is 1 cycle. Handshake to the next group is 1 cycle.
- Simultaneous exc and br redirects: exc wins, br is dropped.

Optional Feature:
PC_PREDICT_EN:
- Defined: adds inputs pred_valid (1) and pred_pc (32).
  - On a handshake with no redirect, pred_valid selects pred_pc instead of fetch_nnpc.
  - Priority: exc > br > pred > sequential.
  - A misaligned pred_pc enters ERR.
- Undefined: the ports are absent and behaviour is as above.

Decomposition:
- Package pc_pkg holds:
  - the state enum {BOOT, RUN, HALT, ERR};
  - the default RESET_PC constant;
  - the function computing the aligned group increment.
- One sub-module, pc_slot_mask: combinational offset-to-mask decoder, parametrised by FETCH_WIDTH.

Test Plan (FETCH_WIDTH=4, RESET_PC=32'hBFC0_0000):
- Release reset with fetch_ready=1 -> valid=0 for 1 cycle, then pc sequence BFC0_0000, BFC0_0010, BFC0_0020; mask=4'b1111; npc=BFC0_0004.
- br redirect to 0x8000_0008 while fetch_ready=0 -> next cycle pc=8000_0008, mask=4'b1100, nnpc=8000_0010; on handshake pc=8000_0010.
- exc (0xBFC0_0380) and br (0x8000_1000) in the same cycle -> pc=BFC0_0380.
- Hold fetch_ready=0 for 5 cycles -> all outputs stable; ready=1 -> single advance by 0x10.
- halt_req=1 -> valid=0 from the next cycle; drop halt_req -> stays halted; exc redirect to BFC0_0380 -> valid=1, pc=BFC0_0380.
- br redirect to 0x8000_0002 -> ERR, adel=1, mask=0, pc frozen under handshakes; exc redirect -> RUN, adel=0. Reset asserted mid-run -> valid=0 immediately, pc=BFC0_0000 without a clock edge.
